pp3_mult_seq_responder: RTL and testbench
=========================================

// Module: pp3_mult_seq_responder
//
// PURPOSE
// Sequential soft multiplier that serves multiply requests when no hard
// qlal4s3 multiplier is available or free. Its operand side corresponds to the
// Amult/Bmult/Valid_mult initiator of the hard cell; it returns the 2*W-bit
// product on a registered result port. It accepts operands via valid/ready,
// computes one shift-add step per cycle and holds the result until consumed.
//
// PARAMETERS
// W      16   operand width in bits (W >= 2); the result is 2*W bits
//
// PORTS
// clk        in   1     single clock; all state updates on the rising edge
// rst        in   1     asynchronous, active-high reset
// req_valid  in   1     operands valid
// req_ready  out  1     responder can accept operands (high only in IDLE)
// req_signed in   1     1: two's-complement operands; 0: unsigned
// req_a      in   W     multiplicand (Amult)
// req_b      in   W     multiplier (Bmult)
// res_valid  out  1     product valid; held until accepted
// res_ready  in   1     consumer accepts the product
// res_data   out  2*W   product, registered
//
// BEHAVIOUR
// - Reset (async, any time, including mid-operation): state=IDLE, req_ready=1,
//   res_valid=0, res_data=0, internal accumulator/counter=0. In-flight work is
//   discarded; no partial result is ever presented.
// - FSM states: IDLE, BUSY, DONE.
//   IDLE: req_ready=1. On req_valid&&req_ready at an edge: latch |a|, |b| (W-bit
//     magnitudes; for signed, magnitudes of -2^(W-1) are 2^(W-1), no overflow),
//     neg = req_signed & (a[W-1]^b[W-1]), acc=0, cnt=0 -> BUSY.
//   BUSY: req_ready=0. Each edge: if mb[cnt] then acc += ma<<cnt; cnt++.
//     On the edge where cnt==W-1: res_data <= neg ? -acc_next : acc_next
//     (2*W-bit two's complement), res_valid<=1 -> DONE.
//   DONE: res_valid=1, res_data stable, req_ready=0. On res_valid&&res_ready:
//     res_valid<=0 -> IDLE. No new request is accepted in the same cycle.
// - Latency: res_valid rises exactly W cycles after the accept edge.
//   Throughput with res_ready tied high: one product per W+2 cycles.
// - Inputs req_* are ignored outside the IDLE accept edge; changing them during
//   BUSY/DONE has no effect on the result.
// - Unsigned mode: full 2*W-bit product, never truncated. Signed mode: exact
//   2*W-bit two's-complement product; (-2^(W-1))^2 = 2^(2W-2) is representable.
// - Zero operand: still takes W cycles; result 0 with neg ignored (−0 == 0).
// - res_ready high while res_valid low has no effect.
//
// TESTING
// 1 unsigned 3 x 5 (W=16) -> res_data=32'h0000000F, res_valid rises 16 cycles
//   after accept edge.
// 2 unsigned 16'hFFFF x 16'hFFFF -> 32'hFFFE0001; signed same -> 32'h00000001.
// 3 signed 16'h8000 x 16'h8000 -> 32'h40000000; signed 16'h8000 x 16'h0001 ->
//   32'hFFFF8000; signed -7 x 0 -> 32'h00000000.
// 4 backpressure: hold res_ready=0 for 10 cycles after res_valid -> res_data
//   and res_valid stable, req_ready=0 throughout; release -> IDLE next edge.
// 5 back-to-back with res_ready=1, req_valid=1 continuously, 4 random pairs ->
//   accept edges spaced 18 cycles apart, all products match reference model.
// 6 assert rst asynchronously at BUSY cnt=7 -> res_valid=0, req_ready=1
//   immediately; next request 2 x 9 -> 32'h00000012 with full 16-cycle latency.

Source files
------------

// File: rtl/pp3_mult_seq_responder.sv
// Sequential shift-add soft multiplier: signed or unsigned W x W -> 2W product.
// Latency: result valid exactly W cycles after the request accept edge.
// Backpressure: accepts only when idle; result is held stable until res_ready.
module pp3_mult_seq_responder #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*W-1:0]   res_data
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  // Latched operand magnitudes and the sign of the final product.
  logic [W-1:0]    ma;
  logic [W-1:0]    mb;
  logic            neg;

  // Running partial-product sum and bit index of the multiplier.
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  acc_next;
  logic [2*W-1:0]  addend;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic            req_neg;
  logic            accept;
  logic            last_step;

  // Operand magnitudes; the most negative value maps to 2^(W-1), which fits in W unsigned bits.
  always_comb begin
    a_mag   = req_a;
    b_mag   = req_b;
    req_neg = 1'b0;
    if (req_signed) begin
      if (req_a[W-1]) a_mag = {W{1'b0}} - req_a;
      if (req_b[W-1]) b_mag = {W{1'b0}} - req_b;
      req_neg = req_a[W-1] ^ req_b[W-1];
    end
  end

  // One shift-add step: add the multiplicand shifted by the current bit position if that bit is set.
  always_comb begin
    addend   = '0;
    if (mb[cnt]) begin
      addend = {{W{1'b0}}, ma} << cnt;
    end
    acc_next  = acc + addend;
    last_step = (cnt == CW'(W - 1));
  end

  assign accept = (state == IDLE) && req_valid;

  // State register; reset discards any in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        // Consuming the result only returns to IDLE; a new request waits a cycle.
        if (res_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, iterate in BUSY, publish the signed-corrected sum on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma       <= '0;
      mb       <= '0;
      neg      <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      res_data <= '0;
    end else begin
      if (accept) begin
        ma  <= a_mag;
        mb  <= b_mag;
        neg <= req_neg;
        acc <= '0;
        cnt <= '0;
      end else if (state == BUSY) begin
        acc <= acc_next;
        if (last_step) begin
          cnt      <= '0;
          // Negating zero yields zero, so a zero operand needs no special case.
          res_data <= neg ? ({2*W{1'b0}} - acc_next) : acc_next;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pp3_mult_seq_responder.sv
// Scoreboard bench: stimulus pushes hand-computed products; a negedge monitor pops on each consumed result.
module tb_pp3_mult_seq_responder;

  localparam int W = 16;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_signed;
  logic [W-1:0]    req_a;
  logic [W-1:0]    req_b;
  logic            res_valid;
  logic            res_ready;
  logic [2*W-1:0]  res_data;

  pp3_mult_seq_responder #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_signed (req_signed),
    .req_a      (req_a),
    .req_b      (req_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [2*W-1:0] exp_q[$];

  int cyc = 0;
  int acc_edge = 0;
  int prev_acc = 0;
  bit have_prev = 1'b0;
  bit pending = 1'b0;
  bit prev_vld = 1'b0;
  bit b2b = 1'b0;

  task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: track accept edges, check latency and spacing, pop and compare each consumed product.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        if (b2b && have_prev)
          chk("b2b_spacing", (cyc + 1 - prev_acc) == W + 2, 64'(cyc + 1 - prev_acc), 64'(W + 2));
        prev_acc  = cyc + 1;
        have_prev = b2b;
        acc_edge  = cyc + 1;
        pending   = 1'b1;
      end
      if (res_valid && !prev_vld && pending) begin
        chk("latency", (cyc - acc_edge) == W, 64'(cyc - acc_edge), 64'(W));
        pending = 1'b0;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1'b0, 64'(res_data), 64'(0));
        end else begin
          logic [2*W-1:0] e;
          e = exp_q.pop_front();
          chk("result", res_data == e, 64'(res_data), 64'(e));
        end
      end
    end
    prev_vld = res_valid;
  end

  // Present a request, wait (bounded) for it to be accepted, record the expected product.
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] e, input bit keep);
    int guard = 0;
    req_signed = s;
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    while (!req_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 1'b0, 64'(0), 64'(1));
    end else begin
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((!req_ready || exp_q.size() != 0) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready || exp_q.size() != 0)
      chk("idle_timeout", 1'b0, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit bad;
    int guard;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    req_a      = '0;
    req_b      = '0;
    res_ready  = 1'b1;
    #2;
    chk("rst_res_valid", res_valid == 1'b0, 64'(res_valid), 64'(0));
    chk("rst_req_ready", req_ready == 1'b1, 64'(req_ready), 64'(1));
    chk("rst_res_data",  res_data == '0, 64'(res_data), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic unsigned product; operands scrambled while busy must not matter.
    issue(1'b0, 16'd3, 16'd5, 32'h0000000F, 1'b0);
    req_a = 16'hABCD; req_b = 16'h1357; req_signed = 1'b1;
    wait_idle();

    issue(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0);
    wait_idle();
    issue(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0);
    wait_idle();
    issue(1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b0);
    wait_idle();
    issue(1'b1, 16'h8000, 16'h0001, 32'hFFFF8000, 1'b0);
    wait_idle();
    issue(1'b1, 16'hFFF9, 16'h0000, 32'h00000000, 1'b0);
    wait_idle();

    // Backpressure: hold the result for 10 cycles, then release.
    res_ready = 1'b0;
    issue(1'b0, 16'h0100, 16'h0003, 32'h00000300, 1'b0);
    guard = 0;
    while (!res_valid && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("bp_valid_seen", res_valid == 1'b1, 64'(res_valid), 64'(1));
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!res_valid || req_ready || res_data != 32'h00000300) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("bp_hold_stable", bad == 1'b0, 64'(res_data), 64'h300);
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", req_ready == 1'b1 && res_valid == 1'b0, 64'({req_ready, res_valid}), 64'b10);
    wait_idle();

    // Back-to-back with req_valid held high and res_ready tied high.
    b2b = 1'b1;
    issue(1'b0, 16'h0100, 16'h0100, 32'h00010000, 1'b1);
    issue(1'b1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA, 1'b1);
    issue(1'b0, 16'h00FF, 16'h0101, 32'h0000FFFF, 1'b1);
    issue(1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b1);
    req_valid = 1'b0;
    wait_idle();
    b2b = 1'b0;

    // Asynchronous reset mid-computation at cnt == 7.
    issue(1'b0, 16'h1234, 16'h0005, 32'h00005B04, 1'b0);
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_res_valid", res_valid == 1'b0, 64'(res_valid), 64'(0));
    chk("midrst_req_ready", req_ready == 1'b1, 64'(req_ready), 64'(1));
    chk("midrst_res_data",  res_data == '0, 64'(res_data), 64'(0));
    exp_q.delete();
    @(posedge clk); #4;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 16'd2, 16'd9, 32'h00000012, 1'b0);
    wait_idle();

    chk("queue_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
